// File: rtl/dm_sba_controller.sv
`default_nettype none
// ============================================================================
// Module   : dm_sba_controller
// Purpose  : System Bus Access sequencer - issues single-beat bus transactions
//            with size/alignment checks, response timeout and autoincrement.
// Revision : 1.0 - initial release
// ============================================================================
module dm_sba_controller #(
    parameter int unsigned TimeoutCycles = 255
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [31:0] sbaddress_i,
    input  logic [31:0] sbdata_i,
    input  logic        sbaddress_write_valid_i,
    input  logic        sbdata_read_valid_i,
    input  logic        sbdata_write_valid_i,
    input  logic        sbreadonaddr_i,
    input  logic        sbreadondata_i,
    input  logic        sbautoincrement_i,
    input  logic [2:0]  sbaccess_i,
    output logic        sbbusy_o,
    output logic [31:0] sbdata_o,
    output logic        sbdata_valid_o,
    output logic [2:0]  sberror_o,
    output logic        sberror_valid_o,
    output logic [31:0] sbaddress_o,
    output logic        sbaddress_valid_o,
    output logic        req_o,
    output logic [31:0] add_o,
    output logic        we_o,
    output logic [31:0] wdata_o,
    output logic [3:0]  be_o,
    input  logic        gnt_i,
    input  logic        r_valid_i,
    input  logic [31:0] r_rdata_i,
    input  logic        r_err_i
);

    localparam int unsigned          c_cnt_w   = $clog2(TimeoutCycles + 2);
    localparam logic [c_cnt_w-1:0]   c_timeout = c_cnt_w'(TimeoutCycles);

    localparam logic [2:0] c_st_idle       = 3'd0;
    localparam logic [2:0] c_st_read       = 3'd1;
    localparam logic [2:0] c_st_write      = 3'd2;
    localparam logic [2:0] c_st_wait_read  = 3'd3;
    localparam logic [2:0] c_st_wait_write = 3'd4;

    logic [2:0]         r_state;
    logic [2:0]         w_next_state;
    logic               r_busy;
    logic               r_latched;
    logic [31:0]        r_addr;
    logic [31:0]        r_data;
    logic [2:0]         r_size;
    logic [c_cnt_w-1:0] r_cnt;
    logic [c_cnt_w-1:0] w_cnt_next;

    logic [31:0]        w_addr;
    logic [31:0]        w_data;
    logic [2:0]         w_size;
    logic               w_size_err;
    logic               w_align_err;
    logic               w_timeout;
    logic [3:0]         w_be;
    logic [31:0]        w_wdata;
    logic [31:0]        w_rmask;
    logic [31:0]        w_rdata;
    logic               w_req;
    logic               w_we;

    logic               w_err_set;
    logic [2:0]         w_err_code;
    logic               w_data_set;
    logic               w_inc_set;

    logic [31:0]        r_sbdata;
    logic               r_sbdata_valid;
    logic [2:0]         r_sberror;
    logic               r_sberror_valid;
    logic [31:0]        r_sbaddress;
    logic               r_sbaddress_valid;

    // The first busy cycle uses the live register values; afterwards the
    // captured copy keeps an outstanding request stable until granted.
    assign w_addr = r_latched ? r_addr : sbaddress_i;
    assign w_data = r_latched ? r_data : sbdata_i;
    assign w_size = r_latched ? r_size : sbaccess_i;

    assign w_size_err  = (w_size > 3'd2);
    assign w_align_err = ((w_size == 3'd1) && w_addr[0]) ||
                         ((w_size == 3'd2) && (w_addr[1:0] != 2'b00));

    assign w_cnt_next = (r_cnt == {c_cnt_w{1'b1}}) ? r_cnt : r_cnt + c_cnt_w'(1);
    assign w_timeout  = (TimeoutCycles != 0) && (w_cnt_next >= c_timeout);

    always_comb begin
        w_be    = 4'b0000;
        w_wdata = w_data;
        w_rmask = 32'hFFFF_FFFF;
        case (w_size)
            3'd0: begin
                w_be    = 4'b0001 << w_addr[1:0];
                w_wdata = {4{w_data[7:0]}};
                w_rmask = 32'h0000_00FF;
            end
            3'd1: begin
                w_be    = 4'b0011 << {w_addr[1], 1'b0};
                w_wdata = {2{w_data[15:0]}};
                w_rmask = 32'h0000_FFFF;
            end
            3'd2:    w_be = 4'b1111;
            default: w_be = 4'b0000;
        endcase
    end

    assign w_rdata = (r_rdata_i >> {w_addr[1:0], 3'b000}) & w_rmask;

    always_comb begin
        w_next_state = r_state;
        w_req        = 1'b0;
        w_err_set    = 1'b0;
        w_err_code   = 3'd0;
        w_data_set   = 1'b0;
        w_inc_set    = 1'b0;
        case (r_state)
            c_st_idle: begin
                if (sbaddress_write_valid_i && sbreadonaddr_i) begin
                    w_next_state = c_st_read;
                end else if (sbdata_write_valid_i) begin
                    w_next_state = c_st_write;
                end else if (sbdata_read_valid_i && sbreadondata_i) begin
                    w_next_state = c_st_read;
                end
            end
            c_st_read, c_st_write: begin
                if (!r_latched && w_size_err) begin
                    w_err_set    = 1'b1;
                    w_err_code   = 3'd4;
                    w_next_state = c_st_idle;
                end else if (!r_latched && w_align_err) begin
                    w_err_set    = 1'b1;
                    w_err_code   = 3'd3;
                    w_next_state = c_st_idle;
                end else begin
                    w_req = 1'b1;
                    // A grant on the last allowed cycle still wins over the timeout.
                    if (gnt_i) begin
                        w_next_state = (r_state == c_st_read) ? c_st_wait_read : c_st_wait_write;
                    end else if (w_timeout) begin
                        w_err_set    = 1'b1;
                        w_err_code   = 3'd1;
                        w_next_state = c_st_idle;
                    end
                end
            end
            c_st_wait_read, c_st_wait_write: begin
                if (r_valid_i) begin
                    w_next_state = c_st_idle;
                    if (r_err_i) begin
                        w_err_set  = 1'b1;
                        w_err_code = 3'd2;
                    end else begin
                        w_data_set = (r_state == c_st_wait_read);
                        w_inc_set  = sbautoincrement_i;
                    end
                end else if (w_timeout) begin
                    w_err_set    = 1'b1;
                    w_err_code   = 3'd1;
                    w_next_state = c_st_idle;
                end
            end
            default: w_next_state = c_st_idle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state   <= c_st_idle;
            r_busy    <= 1'b0;
            r_latched <= 1'b0;
            r_addr    <= 32'd0;
            r_data    <= 32'd0;
            r_size    <= 3'd0;
            r_cnt     <= '0;
        end else begin
            r_state   <= w_next_state;
            r_busy    <= (w_next_state != c_st_idle);
            r_latched <= (r_state != c_st_idle) && (w_next_state != c_st_idle);
            if (((r_state == c_st_read) || (r_state == c_st_write)) && !r_latched) begin
                r_addr <= sbaddress_i;
                r_data <= sbdata_i;
                r_size <= sbaccess_i;
            end
            if (r_state == c_st_idle) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= w_cnt_next;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_sbdata          <= 32'd0;
            r_sbdata_valid    <= 1'b0;
            r_sberror         <= 3'd0;
            r_sberror_valid   <= 1'b0;
            r_sbaddress       <= 32'd0;
            r_sbaddress_valid <= 1'b0;
        end else begin
            r_sbdata_valid    <= w_data_set;
            r_sberror_valid   <= w_err_set;
            r_sbaddress_valid <= w_inc_set;
            if (w_data_set) begin
                r_sbdata <= w_rdata;
            end
            if (w_err_set) begin
                r_sberror <= w_err_code;
            end
            if (w_inc_set) begin
                r_sbaddress <= w_addr + (32'd1 << w_size);
            end
        end
    end

    assign w_we = w_req && (r_state == c_st_write);

    assign sbbusy_o          = r_busy;
    assign sbdata_o          = r_sbdata;
    assign sbdata_valid_o    = r_sbdata_valid;
    assign sberror_o         = r_sberror;
    assign sberror_valid_o   = r_sberror_valid;
    assign sbaddress_o       = r_sbaddress;
    assign sbaddress_valid_o = r_sbaddress_valid;

    assign req_o   = w_req;
    assign add_o   = w_req ? {w_addr[31:2], 2'b00} : 32'd0;
    assign be_o    = w_req ? w_be : 4'b0000;
    assign we_o    = w_we;
    assign wdata_o = w_we ? w_wdata : 32'd0;

endmodule
`default_nettype wire

// File: tb/tb_dm_sba_controller.sv
`timescale 1ns/1ps
`default_nettype none
// Bench for dm_sba_controller: directed scenarios plus a randomized sweep,
// all checked against an arithmetic model of the access rules.
module tb_dm_sba_controller;

    localparam int TO = 8;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic [31:0] sbaddress_i, sbdata_i;
    logic        sbaddress_write_valid_i, sbdata_read_valid_i, sbdata_write_valid_i;
    logic        sbreadonaddr_i, sbreadondata_i, sbautoincrement_i;
    logic [2:0]  sbaccess_i;
    logic        sbbusy_o;
    logic [31:0] sbdata_o;
    logic        sbdata_valid_o;
    logic [2:0]  sberror_o;
    logic        sberror_valid_o;
    logic [31:0] sbaddress_o;
    logic        sbaddress_valid_o;
    logic        req_o;
    logic [31:0] add_o;
    logic        we_o;
    logic [31:0] wdata_o;
    logic [3:0]  be_o;
    logic        gnt_i, r_valid_i, r_err_i;
    logic [31:0] r_rdata_i;

    always #5 clk_i = ~clk_i;

    dm_sba_controller #(.TimeoutCycles(TO)) u_dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .sbaddress_i(sbaddress_i), .sbdata_i(sbdata_i),
        .sbaddress_write_valid_i(sbaddress_write_valid_i),
        .sbdata_read_valid_i(sbdata_read_valid_i),
        .sbdata_write_valid_i(sbdata_write_valid_i),
        .sbreadonaddr_i(sbreadonaddr_i), .sbreadondata_i(sbreadondata_i),
        .sbautoincrement_i(sbautoincrement_i), .sbaccess_i(sbaccess_i),
        .sbbusy_o(sbbusy_o), .sbdata_o(sbdata_o), .sbdata_valid_o(sbdata_valid_o),
        .sberror_o(sberror_o), .sberror_valid_o(sberror_valid_o),
        .sbaddress_o(sbaddress_o), .sbaddress_valid_o(sbaddress_valid_o),
        .req_o(req_o), .add_o(add_o), .we_o(we_o), .wdata_o(wdata_o), .be_o(be_o),
        .gnt_i(gnt_i), .r_valid_i(r_valid_i), .r_rdata_i(r_rdata_i), .r_err_i(r_err_i)
    );

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_sbdata    = 32'd0;
    logic [31:0] exp_sbaddress = 32'd0;
    logic [2:0]  exp_sberror   = 3'd0;

    task automatic clear_inputs();
        sbaddress_write_valid_i = 1'b0;
        sbdata_read_valid_i     = 1'b0;
        sbdata_write_valid_i    = 1'b0;
        gnt_i     = 1'b0;
        r_valid_i = 1'b0;
        r_err_i   = 1'b0;
        r_rdata_i = 32'd0;
    endtask

    // trig: 0 addr-write (readonaddr), 1 data-write, 2 data-read (readondata),
    //       3 addr-write+data-write together, 4 data-write+data-read together,
    //       5 addr-write with readonaddr clear (no access expected).
    // g: grant delay in cycles after the request (>= TO: never granted);
    // r: response delay after the grant; busy_cyc: cycle for a stray trigger.
    task automatic run_txn(input string name, input int trig, input logic [31:0] addr,
                           input logic [31:0] data, input logic [2:0] size, input logic ainc,
                           input int g, input int r, input logic berr,
                           input logic [31:0] rsp, input int busy_cyc);
        int          nbytes, exp_err, req_end, pulse_cyc, resp_cyc, last;
        bit          is_wr, no_txn, ok, exp_dv, exp_ev, exp_av;
        bit          exp_req, exp_busy;
        logic [31:0] mask, word, exp_wd, exp_rd, exp_inc, exp_add;
        logic [3:0]  exp_be;

        no_txn   = (trig == 5);
        is_wr    = (trig == 1) || (trig == 4);
        nbytes   = 1 << size;
        mask     = (nbytes >= 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nbytes)) - 32'd1);
        exp_add  = addr - (addr % 4);
        exp_be   = 4'(((1 << nbytes) - 1) << (addr % 4));
        word     = data & mask;
        exp_wd   = 32'd0;
        for (int k = 0; k < 4; k += nbytes) exp_wd = exp_wd | (word << (8 * k));
        exp_rd   = (rsp >> (8 * (addr % 4))) & mask;
        exp_inc  = addr + nbytes;
        resp_cyc = 2 + g + r;

        if (no_txn) begin
            exp_err = 0; req_end = 0; pulse_cyc = 0;
        end else if (size > 3'd2) begin
            exp_err = 4; req_end = 0; pulse_cyc = 2;
        end else if ((addr % nbytes) != 0) begin
            exp_err = 3; req_end = 0; pulse_cyc = 2;
        end else if (g >= TO) begin
            exp_err = 1; req_end = TO; pulse_cyc = TO + 1;
        end else if (resp_cyc > TO) begin
            exp_err = 1; req_end = 1 + g; pulse_cyc = TO + 1;
        end else begin
            exp_err = berr ? 2 : 0; req_end = 1 + g; pulse_cyc = resp_cyc + 1;
        end
        ok     = !no_txn && (exp_err == 0);
        exp_dv = ok && !is_wr;
        exp_av = ok && ainc;
        exp_ev = (exp_err != 0);
        last   = no_txn ? 4 : pulse_cyc + 2;

        @(negedge clk_i);
        sbaddress_i       = addr;
        sbdata_i          = data;
        sbaccess_i        = size;
        sbautoincrement_i = ainc;
        sbreadonaddr_i    = (trig == 0) || (trig == 3);
        sbreadondata_i    = (trig == 2) || (trig == 4);
        sbaddress_write_valid_i = (trig == 0) || (trig == 3) || (trig == 5);
        sbdata_write_valid_i    = (trig == 1) || (trig == 3) || (trig == 4);
        sbdata_read_valid_i     = (trig == 2) || (trig == 4);

        for (int c = 1; c <= last; c++) begin
            @(negedge clk_i);
            clear_inputs();
            r_rdata_i = $urandom;
            exp_req   = (c <= req_end);
            exp_busy  = !no_txn && (c < pulse_cyc);

            checks++;
            if (req_o !== exp_req) begin
                errors++;
                $display("FAIL %s req_o cyc %0d: got %b expected %b", name, c, req_o, exp_req);
            end
            checks++;
            if (sbbusy_o !== exp_busy) begin
                errors++;
                $display("FAIL %s sbbusy_o cyc %0d: got %b expected %b", name, c, sbbusy_o, exp_busy);
            end
            checks++;
            if ({sbdata_valid_o, sberror_valid_o, sbaddress_valid_o} !==
                {exp_dv && (c == pulse_cyc), exp_ev && (c == pulse_cyc), exp_av && (c == pulse_cyc)}) begin
                errors++;
                $display("FAIL %s pulses{data,err,addr} cyc %0d: got %b%b%b expected %b%b%b", name, c,
                         sbdata_valid_o, sberror_valid_o, sbaddress_valid_o,
                         exp_dv && (c == pulse_cyc), exp_ev && (c == pulse_cyc), exp_av && (c == pulse_cyc));
            end
            if (exp_req && req_o === 1'b1) begin
                checks++;
                if ({add_o, be_o, we_o} !== {exp_add, exp_be, is_wr}) begin
                    errors++;
                    $display("FAIL %s bus cyc %0d: got add=%h be=%h we=%b expected add=%h be=%h we=%b",
                             name, c, add_o, be_o, we_o, exp_add, exp_be, is_wr);
                end
                if (is_wr) begin
                    checks++;
                    if (wdata_o !== exp_wd) begin
                        errors++;
                        $display("FAIL %s wdata_o cyc %0d: got %h expected %h", name, c, wdata_o, exp_wd);
                    end
                end
            end
            if (c == pulse_cyc) begin
                if (exp_dv) exp_sbdata = exp_rd;
                if (exp_ev) exp_sberror = 3'(exp_err);
                if (exp_av) exp_sbaddress = exp_inc;
            end

            if (req_end > 0 && g < TO && c == 1 + g) gnt_i = 1'b1;
            if (req_end > 0 && g < TO && c == resp_cyc) begin
                r_valid_i = 1'b1;
                r_err_i   = berr;
                r_rdata_i = rsp;
            end
            if (c == busy_cyc) sbdata_write_valid_i = 1'b1;
        end

        checks++;
        if ({sbdata_o, sberror_o, sbaddress_o} !== {exp_sbdata, exp_sberror, exp_sbaddress}) begin
            errors++;
            $display("FAIL %s held outputs: got data=%h err=%0d addr=%h expected data=%h err=%0d addr=%h",
                     name, sbdata_o, sberror_o, sbaddress_o, exp_sbdata, exp_sberror, exp_sbaddress);
        end
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        clear_inputs();
        sbaddress_i = 32'h1234_5677; sbdata_i = 32'hFFFF_FFFF; sbaccess_i = 3'd2;
        sbreadonaddr_i = 1'b0; sbreadondata_i = 1'b0; sbautoincrement_i = 1'b0;
        repeat (3) @(negedge clk_i);
        checks++;
        if ({sbbusy_o, req_o, we_o, sbdata_valid_o, sberror_valid_o, sbaddress_valid_o} !== 6'b0) begin
            errors++;
            $display("FAIL reset flags: got %b%b%b%b%b%b expected 000000", sbbusy_o, req_o, we_o,
                     sbdata_valid_o, sberror_valid_o, sbaddress_valid_o);
        end
        checks++;
        if ({add_o, wdata_o, be_o} !== 68'd0) begin
            errors++;
            $display("FAIL reset bus: got add=%h wdata=%h be=%h expected zeros", add_o, wdata_o, be_o);
        end
        checks++;
        if ({sbdata_o, sberror_o, sbaddress_o} !== 67'd0) begin
            errors++;
            $display("FAIL reset regs: got data=%h err=%0d addr=%h expected zeros", sbdata_o, sberror_o, sbaddress_o);
        end
        rst_ni = 1'b1;
        repeat (2) @(negedge clk_i);
        checks++;
        if ({sbbusy_o, req_o} !== 2'b00) begin
            errors++;
            $display("FAIL reset idle: got busy=%b req=%b expected 0 0", sbbusy_o, req_o);
        end
    endtask

    task automatic test_read_on_addr();
        run_txn("read_on_addr", 0, 32'h0000_1000, 32'h0, 3'd2, 1'b0, 0, 0, 1'b0, 32'hDEAD_BEEF, 0);
        run_txn("read_on_data", 2, 32'h0000_1002, 32'h0, 3'd1, 1'b0, 1, 2, 1'b0, 32'hCAFE_F00D, 0);
    endtask

    task automatic test_byte_write_autoinc();
        run_txn("byte_write_ainc", 1, 32'h0000_2003, 32'h0000_00A5, 3'd0, 1'b1, 0, 0, 1'b0, 32'h0, 0);
        run_txn("half_write", 1, 32'h0000_2006, 32'h1234_BEEF, 3'd1, 1'b0, 2, 1, 1'b0, 32'h0, 0);
        run_txn("wrap_ainc", 1, 32'hFFFF_FFFC, 32'h5555_AAAA, 3'd2, 1'b1, 0, 0, 1'b0, 32'h0, 0);
    endtask

    task automatic test_alignment();
        run_txn("half_misaligned", 0, 32'h0000_3001, 32'h0, 3'd1, 1'b0, 0, 0, 1'b0, 32'h0, 0);
        run_txn("word_misaligned", 1, 32'h0000_3002, 32'h0, 3'd2, 1'b1, 0, 0, 1'b0, 32'h0, 0);
        run_txn("bad_size", 0, 32'h0000_3000, 32'h0, 3'd3, 1'b0, 0, 0, 1'b0, 32'h0, 0);
        run_txn("bad_size_misaligned", 1, 32'h0000_3001, 32'h0, 3'd3, 1'b0, 0, 0, 1'b0, 32'h0, 0);
    endtask

    task automatic test_bus_error_timeout();
        run_txn("bus_error_read", 0, 32'h0000_4000, 32'h0, 3'd2, 1'b1, 0, 1, 1'b1, 32'h1111_2222, 0);
        run_txn("timeout_no_gnt", 1, 32'h0000_4004, 32'h77, 3'd2, 1'b0, 100, 0, 1'b0, 32'h0, 0);
        run_txn("timeout_late_rsp", 0, 32'h0000_4008, 32'h0, 3'd2, 1'b0, 0, 7, 1'b0, 32'h3333_4444, 0);
        run_txn("rsp_at_limit_wins", 0, 32'h0000_4011, 32'h0, 3'd0, 1'b1, 2, 4, 1'b0, 32'h8899_AABB, 0);
    endtask

    task automatic test_priority_and_busy();
        run_txn("addr_beats_data", 3, 32'h0000_5000, 32'hABCD_0123, 3'd2, 1'b0, 0, 0, 1'b0, 32'h0BAD_F00D, 0);
        run_txn("write_beats_read", 4, 32'h0000_5004, 32'hABCD_0123, 3'd2, 1'b0, 0, 0, 1'b0, 32'h0, 0);
        run_txn("no_readonaddr", 5, 32'h0000_5008, 32'h0, 3'd2, 1'b0, 0, 0, 1'b0, 32'h0, 0);
        run_txn("trigger_while_busy", 0, 32'h0000_500C, 32'h0, 3'd2, 1'b0, 0, 3, 1'b0, 32'h600D_CAFE, 3);
    endtask

    task automatic test_reset_mid();
        // Reset while the write request is still waiting for a grant.
        @(negedge clk_i);
        sbaddress_i = 32'h0000_6000; sbdata_i = 32'h1; sbaccess_i = 3'd2; sbautoincrement_i = 1'b1;
        sbdata_write_valid_i = 1'b1;
        @(negedge clk_i);
        clear_inputs();
        checks++;
        if (req_o !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid req before reset: got %b expected 1", req_o);
        end
        #2 rst_ni = 1'b0;
        #1;
        checks++;
        if ({req_o, sbbusy_o} !== 2'b00) begin
            errors++;
            $display("FAIL rst_mid write: got req=%b busy=%b expected 0 0", req_o, sbbusy_o);
        end
        @(negedge clk_i);
        rst_ni = 1'b1;
        exp_sbdata = 32'd0; exp_sberror = 3'd0; exp_sbaddress = 32'd0;

        // Reset while waiting for the write response, then a late response.
        @(negedge clk_i);
        sbdata_write_valid_i = 1'b1;
        @(negedge clk_i);
        clear_inputs();
        gnt_i = 1'b1;
        repeat (2) @(negedge clk_i);
        gnt_i = 1'b0;
        checks++;
        if (sbbusy_o !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid wait_write busy: got %b expected 1", sbbusy_o);
        end
        #2 rst_ni = 1'b0;
        #1;
        checks++;
        if ({req_o, sbbusy_o} !== 2'b00) begin
            errors++;
            $display("FAIL rst_mid wait_write: got req=%b busy=%b expected 0 0", req_o, sbbusy_o);
        end
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        r_valid_i = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk_i);
            clear_inputs();
            checks++;
            if ({sbdata_valid_o, sberror_valid_o, sbaddress_valid_o, sbbusy_o, req_o} !== 5'b0) begin
                errors++;
                $display("FAIL rst_mid late rsp cyc %0d: got dv=%b ev=%b av=%b busy=%b req=%b expected all 0",
                         c, sbdata_valid_o, sberror_valid_o, sbaddress_valid_o, sbbusy_o, req_o);
            end
        end
        checks++;
        if ({sbdata_o, sberror_o, sbaddress_o} !== 67'd0) begin
            errors++;
            $display("FAIL rst_mid regs: got data=%h err=%0d addr=%h expected zeros", sbdata_o, sberror_o, sbaddress_o);
        end
    endtask

    task automatic test_random();
        int          trig, sv, g, r;
        logic [2:0]  size;
        logic [31:0] addr;
        for (int i = 0; i < 40; i++) begin
            trig = $urandom_range(0, 5);
            sv   = $urandom_range(0, 9);
            size = (sv == 9) ? 3'd3 : 3'(sv % 3);
            addr = $urandom;
            if (size <= 3'd2 && $urandom_range(0, 3) != 0)
                addr = addr - (addr % (32'd1 << size));
            g = $urandom_range(0, 3);
            r = $urandom_range(0, 3);
            run_txn("random", trig, addr, $urandom, size, 1'($urandom_range(0, 1)), g, r,
                    ($urandom_range(0, 7) == 0), $urandom, 0);
        end
    endtask

    initial begin
        test_reset();
        test_read_on_addr();
        test_byte_write_autoinc();
        test_alignment();
        test_bus_error_timeout();
        test_priority_and_busy();
        test_reset_mid();
        test_random();
        repeat (2) @(negedge clk_i);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
